// File: rtl/fdiv_pkg.sv
// rtl/fdiv_pkg.sv - shared types and constants for the fdiv scheduler
package fdiv_pkg;

    localparam int FDIV_LAT = 5;
    localparam int TAG_ID_W = 3;

    typedef logic [31:0] fp32_t;

    typedef struct packed {
        logic                v;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fdiv_sched_rr_arbiter.sv
// rtl/fdiv_sched_rr_arbiter.sv - combinational round-robin arbiter starting at ptr
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         eligible,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_any
);

    localparam int IW = $clog2(N);

    // Walk ptr, ptr+1, ... with wrap and grant the first eligible index.
    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!grant_any && eligible[j]) begin
                grant_any = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fdiv_sched.sv
// rtl/fdiv_sched.sv - shares one pipelined fdiv unit among N_REQ requesters
module fdiv_sched
    import fdiv_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DIV_LAT = FDIV_LAT,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [32*N_REQ-1:0]      req_a,
    input  logic [32*N_REQ-1:0]      req_b,
    output fp32_t                    div_a,
    output fp32_t                    div_b,
    output logic                     div_vld,
    input  fp32_t                    div_q,
    output logic                     rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output fp32_t                    rsp_q
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = 4;

    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q [N_REQ];
    logic [CW-1:0]    cnt_d [N_REQ];
    tag_t             tag_q [DIV_LAT+1];
    tag_t             tag_d [DIV_LAT+1];
    fp32_t            div_a_q, div_a_d, div_b_q, div_b_d;
    logic             div_vld_q, div_vld_d;
    logic [N_REQ-1:0] eligible, grant, rsp_dec;
    logic [IW-1:0]    grant_idx;
    logic             grant_any, accept;

    // A requester competes only while it has an op pending and room under its cap.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] && (cnt_q[i] < CW'(MAX_OUT));
        end
    end

    rr_arbiter #(.N(N_REQ)) u_arb (
        .eligible  (eligible),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant & {N_REQ{rstn}};
    assign accept    = grant_any & rstn;
    assign rsp_valid = tag_q[DIV_LAT].v & rstn;
    assign rsp_id    = tag_q[DIV_LAT].id[IW-1:0];
    assign rsp_q     = div_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign div_vld   = div_vld_q;

    // Next state: pointer advance, operand capture, tag shift and counter update.
    always_comb begin
        ptr_d     = ptr_q;
        div_a_d   = div_a_q;
        div_b_d   = div_b_q;
        div_vld_d = accept;
        tag_d[0]  = '0;
        if (accept) begin
            ptr_d      = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            div_a_d    = req_a[32*int'(grant_idx) +: 32];
            div_b_d    = req_b[32*int'(grant_idx) +: 32];
            tag_d[0].v  = 1'b1;
            tag_d[0].id = TAG_ID_W'(grant_idx);
        end
        for (int k = 1; k <= DIV_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        for (int i = 0; i < N_REQ; i++) begin
            rsp_dec[i] = rsp_valid && (rsp_id == IW'(i));
            cnt_d[i]   = cnt_q[i];
            if (accept && grant[i] && !rsp_dec[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (rsp_dec[i] && !(accept && grant[i])) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    // State registers; reset drops every in-flight tag so stale quotients are ignored.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q     <= '0;
            div_a_q   <= '0;
            div_b_q   <= '0;
            div_vld_q <= 1'b0;
            for (int k = 0; k <= DIV_LAT; k++) begin
                tag_q[k] <= '0;
            end
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            div_a_q   <= div_a_d;
            div_b_q   <= div_b_d;
            div_vld_q <= div_vld_d;
            for (int k = 0; k <= DIV_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A response for a requester with nothing outstanding means tracking is broken.
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < N_REQ; i++) begin
                assert (!(rsp_dec[i] && cnt_q[i] == '0));
                assert (cnt_q[i] <= CW'(MAX_OUT));
            end
        end
    end

endmodule

// File: tb/tb_fdiv_sched.sv
// tb/tb_fdiv_sched.sv - self-checking bench for fdiv_sched with a behavioural fdiv unit
module tb_fdiv_sched;

    localparam int N       = 4;
    localparam int DIV_LAT = 5;
    localparam int MAX_OUT = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic [N-1:0]     req_valid, req_ready;
    logic [32*N-1:0]  req_a, req_b;
    logic [31:0]      div_a, div_b, div_q, rsp_q;
    logic             div_vld, rsp_valid;
    logic [1:0]       rsp_id;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    logic [31:0] ta [6];
    logic [31:0] tb [6];
    logic [31:0] tq [6];
    int          opsel [N];

    fdiv_sched #(.N_REQ(N), .DIV_LAT(DIV_LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_vld   (div_vld),
        .div_q     (div_q),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fdiv_f(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] da, db, rq;
        logic [10:0] e;
        real r;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
        da = {a[31], {3'b000, a[30:23]} + 11'd896, a[22:0], 29'd0};
        db = {b[31], {3'b000, b[30:23]} + 11'd896, b[22:0], 29'd0};
        r  = $bitstoreal(da) / $bitstoreal(db);
        rq = $realtobits(r);
        e  = rq[62:52] - 11'd896;
        return {rq[63], e[7:0], rq[51:29]};
    endfunction

    logic [31:0] dq_pipe [DIV_LAT];
    always @(posedge clk) begin
        dq_pipe[0] <= fdiv_f(div_a, div_b);
        for (int k = 1; k < DIV_LAT; k++) dq_pipe[k] <= dq_pipe[k-1];
    end
    assign div_q = dq_pipe[DIV_LAT-1];

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = ta[opsel[i]];
            req_b[32*i +: 32] = tb[opsel[i]];
        end
    endtask

    task automatic apply_reset();
        req_valid = '0;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        rstn = 1'b0;
        drive_ops();
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000) $display("FAIL rst_ready got %b exp 0000", req_ready); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); else passed++;
        @(posedge clk); #1;
        checks++; if (div_vld !== 1'b0) $display("FAIL rst_div_vld got %b exp 0", div_vld); else passed++;
        checks++; if (div_a !== 32'd0 || div_b !== 32'd0) $display("FAIL rst_div_ab got %h/%h exp 0/0", div_a, div_b); else passed++;
        req_valid = '0;
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_idle_rsp got %b exp 0", rsp_valid); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_single_op();
        apply_reset();
        opsel[0] = 0;
        drive_ops();
        req_valid = 4'b0001;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready got %b exp 0001", req_ready); else passed++;
        @(posedge clk); #1;
        req_valid = '0;
        for (int k = 1; k <= DIV_LAT + 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (div_vld !== 1'b1 || div_a !== 32'h40400000 || div_b !== 32'h40000000)
                    $display("FAIL single_issue got vld=%b a=%h b=%h exp 1/40400000/40000000", div_vld, div_a, div_b);
                else passed++;
            end
            checks++;
            if (rsp_valid !== (k == 1 + DIV_LAT)) $display("FAIL single_rsp_valid k=%0d got %b exp %b", k, rsp_valid, (k == 1 + DIV_LAT));
            else passed++;
            if (k == 1 + DIV_LAT) begin
                checks++;
                if (rsp_id !== 2'd0 || rsp_q !== 32'h3FC00000) $display("FAIL single_rsp got id=%0d q=%h exp 0/3fc00000", rsp_id, rsp_q);
                else passed++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_round_robin();
        int r;
        apply_reset();
        for (int i = 0; i < N; i++) opsel[i] = 0;
        drive_ops();
        for (int k = 0; k < 16 + DIV_LAT + 3; k++) begin
            req_valid = (k < 16) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            checks++;
            if (req_ready !== ((k < 16) ? 4'(1 << (k % 4)) : 4'b0000))
                $display("FAIL rr_ready k=%0d got %b exp %b", k, req_ready, (k < 16) ? 4'(1 << (k % 4)) : 4'b0000);
            else passed++;
            r = k - 1 - DIV_LAT;
            checks++;
            if (rsp_valid !== (r >= 0 && r < 16)) $display("FAIL rr_rsp_valid k=%0d got %b exp %b", k, rsp_valid, (r >= 0 && r < 16));
            else passed++;
            if (r >= 0 && r < 16) begin
                checks++;
                if (rsp_id !== 2'(r % 4) || rsp_q !== 32'h3FC00000)
                    $display("FAIL rr_rsp k=%0d got id=%0d q=%h exp %0d/3fc00000", k, rsp_id, rsp_q, r % 4);
                else passed++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_max_out();
        int acc_k [$];
        int outst;
        int first_rsp;
        int acc_before;
        logic exp_rsp;
        apply_reset();
        outst = 0;
        first_rsp = -1;
        acc_before = 0;
        opsel[1] = 1;
        drive_ops();
        for (int k = 0; k < 30; k++) begin
            req_valid = (k < 22) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            exp_rsp = (acc_k.size() > 0) && (acc_k[0] + 1 + DIV_LAT == k);
            checks++;
            if (req_ready !== ((k < 22 && outst < MAX_OUT) ? 4'b0010 : 4'b0000))
                $display("FAIL max_ready k=%0d got %b exp %b", k, req_ready, (k < 22 && outst < MAX_OUT) ? 4'b0010 : 4'b0000);
            else passed++;
            checks++;
            if (rsp_valid !== exp_rsp) $display("FAIL max_rsp_valid k=%0d got %b exp %b", k, rsp_valid, exp_rsp);
            else passed++;
            if (exp_rsp) begin
                checks++;
                if (rsp_id !== 2'd1 || rsp_q !== 32'h40000000) $display("FAIL max_rsp k=%0d got id=%0d q=%h exp 1/40000000", k, rsp_id, rsp_q);
                else passed++;
                void'(acc_k.pop_front());
                outst--;
                if (first_rsp < 0) first_rsp = k;
            end
            if (req_ready[1] && req_valid[1]) begin
                acc_k.push_back(k);
                outst++;
                if (first_rsp < 0) acc_before++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (acc_before !== MAX_OUT) $display("FAIL max_accepts_before_rsp got %0d exp %0d", acc_before, MAX_OUT);
        else passed++;
    endtask

    task automatic test_skip_full();
        apply_reset();
        opsel[1] = 0; opsel[2] = 2; opsel[3] = 3;
        drive_ops();
        for (int k = 0; k < 4; k++) begin
            req_valid = 4'b0100;
            @(negedge clk);
            checks++; if (req_ready !== 4'b0100) $display("FAIL skip_fill k=%0d got %b exp 0100", k, req_ready); else passed++;
            @(posedge clk); #1;
        end
        req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) $display("FAIL skip_req1 got %b exp 0010", req_ready); else passed++;
        @(posedge clk); #1;
        req_valid = 4'b1100;
        @(negedge clk);
        checks++; if (req_ready !== 4'b1000) $display("FAIL skip_grant got %b exp 1000", req_ready); else passed++;
        checks++; if (div_vld !== 1'b1) $display("FAIL skip_prev_slot got %b exp 1", div_vld); else passed++;
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (div_vld !== 1'b1 || div_a !== ta[3] || div_b !== tb[3])
            $display("FAIL skip_issue got vld=%b a=%h b=%h exp 1/%h/%h", div_vld, div_a, div_b, ta[3], tb[3]);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_stream();
        apply_reset();
        for (int i = 0; i < N; i++) opsel[i] = 0;
        drive_ops();
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'b0111;
            @(negedge clk);
            checks++; if (req_ready !== 4'(1 << k)) $display("FAIL mid_pre k=%0d got %b exp %b", k, req_ready, 4'(1 << k)); else passed++;
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) $display("FAIL mid_in_reset got ready=%b rsp=%b exp 0000/0", req_ready, rsp_valid); else passed++;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) $display("FAIL mid_first_grant got %b exp 0001", req_ready); else passed++;
        @(posedge clk); #1;
        req_valid = '0;
        for (int m = 1; m <= DIV_LAT + 4; m++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== (m == 1 + DIV_LAT)) $display("FAIL mid_rsp m=%0d got %b exp %b", m, rsp_valid, (m == 1 + DIV_LAT));
            else passed++;
            @(posedge clk); #1;
        end
        for (int n = 0; n < 6; n++) begin
            req_valid = 4'b0010;
            @(negedge clk);
            checks++;
            if (req_ready !== ((n < MAX_OUT) ? 4'b0010 : 4'b0000))
                $display("FAIL mid_cnt n=%0d got %b exp %b", n, req_ready, (n < MAX_OUT) ? 4'b0010 : 4'b0000);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        int          id;
        logic [31:0] q;
        int          due;
    } sb_t;

    task automatic test_random();
        sb_t         sb [$];
        sb_t         ent;
        int          outst [N];
        int          seen [N];
        int          mptr;
        int          j;
        logic [N-1:0] er;
        logic        ev;
        apply_reset();
        mptr = 0;
        for (int i = 0; i < N; i++) begin
            outst[i] = 0;
            seen[i] = 0;
        end
        for (int c = 0; c < 10000 + DIV_LAT + 3; c++) begin
            for (int i = 0; i < N; i++) opsel[i] = $urandom_range(0, 5);
            drive_ops();
            req_valid = (c < 10000) ? 4'($urandom) : 4'b0000;
            @(negedge clk);
            er = '0;
            for (int k = 0; k < N; k++) begin
                j = (mptr + k) % N;
                if (er == '0 && req_valid[j] && outst[j] < MAX_OUT) er[j] = 1'b1;
            end
            ev = (sb.size() > 0) && (sb[0].due == cyc);
            checks++;
            if (req_ready !== er) $display("FAIL rnd_ready c=%0d got %b exp %b", c, req_ready, er);
            else passed++;
            checks++;
            if (rsp_valid !== ev) $display("FAIL rnd_rsp_valid c=%0d got %b exp %b", c, rsp_valid, ev);
            else passed++;
            if (ev) begin
                checks++;
                if (rsp_id !== 2'(sb[0].id) || rsp_q !== sb[0].q)
                    $display("FAIL rnd_rsp c=%0d got id=%0d q=%h exp %0d/%h", c, rsp_id, rsp_q, sb[0].id, sb[0].q);
                else passed++;
                outst[sb[0].id]--;
                void'(sb.pop_front());
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) seen[i]++;
                if (rsp_valid && rsp_id == 2'(i)) seen[i]--;
            end
            for (int i = 0; i < N; i++) begin
                if (er[i]) begin
                    ent.id  = i;
                    ent.q   = tq[opsel[i]];
                    ent.due = cyc + 1 + DIV_LAT;
                    sb.push_back(ent);
                    outst[i]++;
                    mptr = (i + 1) % N;
                end
            end
            checks++;
            if (seen[0] > MAX_OUT || seen[1] > MAX_OUT || seen[2] > MAX_OUT || seen[3] > MAX_OUT)
                $display("FAIL rnd_cap c=%0d got %0d %0d %0d %0d exp <= %0d", c, seen[0], seen[1], seen[2], seen[3], MAX_OUT);
            else passed++;
            @(posedge clk); #1;
        end
        checks++;
        if (sb.size() != 0) $display("FAIL rnd_drain got %0d pending exp 0", sb.size());
        else passed++;
    endtask

    initial begin
        ta[0] = 32'h40400000; tb[0] = 32'h40000000; tq[0] = 32'h3FC00000;
        ta[1] = 32'h41200000; tb[1] = 32'h40A00000; tq[1] = 32'h40000000;
        ta[2] = 32'h3F800000; tb[2] = 32'h40800000; tq[2] = 32'h3E800000;
        ta[3] = 32'h40C00000; tb[3] = 32'h40000000; tq[3] = 32'h40400000;
        ta[4] = 32'h41000000; tb[4] = 32'h3F000000; tq[4] = 32'h41800000;
        ta[5] = 32'hC1400000; tb[5] = 32'h40800000; tq[5] = 32'hC0400000;
        for (int i = 0; i < N; i++) opsel[i] = 0;
        rstn = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        @(posedge clk); #1;
        test_reset();
        test_single_op();
        test_round_robin();
        test_max_out();
        test_skip_full();
        test_reset_mid_stream();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
